// File: rtl/wb_pkg.sv
// Shared Wishbone B3 encodings and the burst-master state type.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_beat_buf.sv
// One-entry valid/ready holding register for write beats.
// in_ready stays high while the entry is being drained in the same cycle,
// so a full-rate producer/consumer pair sustains one beat per cycle.
module wb_beat_buf #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_pop,
    output logic [DW-1:0] out_data
);

    logic          full_q;
    logic [DW-1:0] data_q;

    // Accept when empty or when the held beat leaves this cycle.
    always_comb begin
        in_ready = enable && (!full_q || out_pop);
    end

    assign out_valid = full_q;
    assign out_data  = data_q;

    // Entry occupancy and payload; flush discards a beat stranded by an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (flush) begin
            full_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_pop) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 initiator: one command becomes a classic single or linear
// incrementing burst; write beats stream in, read beats stream out.
module wb_burst_master #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [29:0]      cmd_adr,
    input  logic [3:0]       cmd_sel,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             done,
    output logic             err,
    output logic [29:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);

    import wb_pkg::*;

    localparam int unsigned LW1 = LEN_W + 1;
    localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    wb_state_t        state_q, state_d;
    logic             abort;
    logic             accept;
    logic             xfer;
    logic             stb;
    logic             ack_ok;
    logic             bus_err;
    logic             last;
    logic             tmo_hit;
    logic             pop;
    logic             buf_en;
    logic             buf_flush;
    logic             buf_full;
    logic [31:0]      buf_data;

    logic             cmd_ready_q;
    logic             we_q;
    logic             len_zero_q;
    logic             err_q;
    logic             rd_valid_q;
    logic [29:0]      adr_q;
    logic [3:0]       sel_q;
    logic [LEN_W-1:0] beat_q;
    logic [LW1-1:0]   load_q;
    logic [31:0]      rd_data_q;
    logic [TW-1:0]    tmo_q;

    // Bus-side qualifiers; only strobed terminations count.
    always_comb begin
        xfer      = (state_q == ST_XFER);
        accept    = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
        stb       = xfer && (!we_q || buf_full);
        ack_ok    = stb && wb_ack_i && !wb_err_i;
        bus_err   = stb && wb_err_i;
        last      = (beat_q == '0);
        tmo_hit   = (TIMEOUT != 0) && stb && !wb_ack_i && !wb_err_i && (tmo_q == TMO_LAST);
        pop       = ack_ok && we_q;
        buf_en    = xfer && we_q && (load_q != '0);
        buf_flush = (state_q == ST_DONE);
    end

    // Next state: error or timeout aborts, final ack completes.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_XFER;
            ST_XFER: begin
                if (bus_err || tmo_hit) begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end else if (ack_ok && last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; async reset drops cyc/stb immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Command latch, address/beat counters, read capture, timeout counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmd_ready_q <= 1'b0;
            we_q        <= 1'b0;
            len_zero_q  <= 1'b0;
            err_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            beat_q      <= '0;
            load_q      <= '0;
            rd_data_q   <= '0;
            tmo_q       <= '0;
        end else begin
            cmd_ready_q <= (state_d == ST_IDLE);
            err_q       <= (state_d == ST_DONE) && abort;
            rd_valid_q  <= ack_ok && !we_q;
            if (ack_ok && !we_q) rd_data_q <= wb_dat_i;

            if (!stb || wb_ack_i || wb_err_i) tmo_q <= '0;
            else                              tmo_q <= tmo_q + TW'(1);

            if (accept) begin
                we_q       <= cmd_we;
                sel_q      <= cmd_sel;
                adr_q      <= cmd_adr;
                beat_q     <= cmd_len;
                len_zero_q <= (cmd_len == '0);
                load_q     <= cmd_we ? ({1'b0, cmd_len} + LW1'(1)) : '0;
            end else begin
                if (ack_ok) begin
                    adr_q <= adr_q + 30'd1;
                    if (!last) beat_q <= beat_q - LEN_W'(1);
                end
                // load_q limits intake to the command's beat count.
                if (wr_valid && wr_ready) load_q <= load_q - LW1'(1);
            end
        end
    end

    wb_beat_buf #(
        .DW (32)
    ) u_beat_buf (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .enable    (buf_en),
        .flush     (buf_flush),
        .in_valid  (wr_valid),
        .in_ready  (wr_ready),
        .in_data   (wr_data),
        .out_valid (buf_full),
        .out_pop   (pop),
        .out_data  (buf_data)
    );

    // Output mapping; cti follows the remaining-beat count.
    always_comb begin
        cmd_ready = cmd_ready_q;
        rd_valid  = rd_valid_q;
        rd_data   = rd_data_q;
        done      = (state_q == ST_DONE);
        err       = err_q;
        wb_adr_o  = adr_q;
        wb_dat_o  = buf_data;
        wb_sel_o  = sel_q;
        wb_cyc_o  = xfer;
        wb_stb_o  = stb;
        wb_we_o   = we_q;
        wb_bte_o  = BTE_LINEAR;
        if (!xfer || len_zero_q) wb_cti_o = CTI_CLASSIC;
        else if (last)           wb_cti_o = CTI_EOB;
        else                     wb_cti_o = CTI_INCR;
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a scoreboarded Wishbone slave.
module tb_wb_burst_master;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [29:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [3:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    wb_burst_master #(
        .LEN_W   (4),
        .TIMEOUT (16)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_sel   (cmd_sel),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_cti_o  (wb_cti_o),
        .wb_bte_o  (wb_bte_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    typedef struct {
        logic [29:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] rd_exp[$];
    logic [31:0] wr_q[$];

    int errors = 0;
    int checks = 0;

    // slave / source configuration, written by the directed sequence
    int unsigned wmin = 0, wmax = 0;
    bit          silent = 0, glitch = 0, wr_gaps = 0;
    int          err_beat = -1;
    int unsigned slv_wait = 0, slv_target = 0;
    int          slv_beat = 0;

    // monitor statistics
    int unsigned done_cnt = 0, cyc_rises = 0, stb_cycles = 0;
    bit          cyc_prev = 0, err_prev = 0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave + write source drive just after the edge; monitor samples mid-cycle.
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        wr_valid = 1'b0;
        wr_data  = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_stb_o) begin
                if (!silent && slv_wait >= slv_target) begin
                    wb_ack_i = 1'b1;
                    if (err_beat >= 0 && slv_beat == err_beat) wb_err_i = 1'b1;
                    else slv_beat++;
                    slv_wait   = 0;
                    slv_target = $urandom_range(wmax, wmin);
                end else begin
                    slv_wait++;
                end
            end else if (glitch) begin
                wb_ack_i = 1'($urandom_range(1, 0));
            end
            wb_dat_i = mem_rd(wb_adr_o);
            wr_valid = (wr_q.size() != 0) && (!wr_gaps || $urandom_range(2, 0) != 0);
            wr_data  = (wr_q.size() != 0) ? wr_q[0] : 32'h0;

            @(negedge sys_clk);
            if (err_prev) check("cyc_after_err", wb_cyc_o, 1'b0);
            err_prev = wb_stb_o && wb_err_i;
            if (wb_stb_o && wb_ack_i && !wb_err_i) begin
                bit have;
                have = (exp_beats.size() != 0);
                check("beat_extra", have, 1'b1);
                if (have) begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat",
                          {wb_adr_o, wb_cti_o, wb_we_o, wb_sel_o, wb_bte_o, wb_cyc_o,
                           (wb_we_o ? wb_dat_o : 32'h0)},
                          {b.adr, b.cti, b.we, b.sel, 2'b00, 1'b1, b.dat});
                end
            end
            if (wr_valid && wr_ready && wr_q.size() != 0) void'(wr_q.pop_front());
            if (rd_valid) begin
                bit have;
                have = (rd_exp.size() != 0);
                check("rd_extra", have, 1'b1);
                if (have) check("rd_data", rd_data, rd_exp.pop_front());
            end
            if (done) done_cnt++;
            if (wb_cyc_o && !cyc_prev) cyc_rises++;
            cyc_prev = wb_cyc_o;
            if (wb_stb_o) stb_cycles++;
        end
    end

    task automatic set_slave(input int unsigned lo, input int unsigned hi, input bit sil,
                             input bit glt, input bit gaps, input int eb);
        wmin = lo; wmax = hi; silent = sil; glitch = glt; wr_gaps = gaps; err_beat = eb;
        slv_wait = 0; slv_beat = 0; slv_target = $urandom_range(hi, lo);
    endtask

    task automatic issue_cmd(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                             input int unsigned len, input int unsigned n_ok);
        beat_t       b;
        logic [31:0] d;
        bit          got;
        for (int unsigned i = 0; i <= len; i++) begin
            d = $urandom();
            if (we) wr_q.push_back(d);
            if (i < n_ok) begin
                b.adr = adr + 30'(i);
                b.cti = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
                b.we  = we;
                b.sel = sel;
                b.dat = we ? d : 32'h0;
                exp_beats.push_back(b);
                if (!we) rd_exp.push_back(mem_rd(b.adr));
            end
        end
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge sys_clk);
            if (cmd_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        check("cmd_ready_wait", got, 1'b1);
        if (got) begin
            cmd_valid = 1'b1;
            cmd_we    = we;
            cmd_adr   = adr;
            cmd_sel   = sel;
            cmd_len   = 4'(len);
            @(posedge sys_clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic run_cmd(input string tag, input logic we, input logic [29:0] adr,
                           input logic [3:0] sel, input int unsigned len,
                           input int unsigned n_ok, input logic exp_err,
                           input int unsigned exp_stb);
        int unsigned r0, s0;
        bit          got;
        logic        e;
        r0 = cyc_rises;
        s0 = stb_cycles;
        issue_cmd(we, adr, sel, len, n_ok);
        got = 0;
        e   = 1'bx;
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                got = 1;
                e   = err;
                break;
            end
        end
        check({tag, "_done"}, got, 1'b1);
        check({tag, "_err"}, e, exp_err);
        @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
        check({tag, "_beats_left"}, exp_beats.size(), 0);
        check({tag, "_rd_left"}, rd_exp.size(), 0);
        check({tag, "_cyc_rises"}, cyc_rises - r0, 1);
        if (exp_stb != 0) check({tag, "_stb_cycles"}, stb_cycles - s0, exp_stb);
        wr_q.delete();
        exp_beats.delete();
        rd_exp.delete();
    endtask

    initial begin
        int unsigned dc;
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_sel   = '0;
        cmd_len   = '0;

        #23;
        check("reset_outputs",
              {cmd_ready, wb_cyc_o, wb_stb_o, done, err, rd_valid, wr_ready,
               wb_cti_o, wb_bte_o, wb_adr_o, rd_data}, '0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        check("ready_before_clk", cmd_ready, 1'b0);
        @(posedge sys_clk);
        #1;
        check("ready_after_clk", cmd_ready, 1'b1);

        // single classic read, one wait state
        set_slave(1, 1, 0, 0, 0, -1);
        run_cmd("rd_single", 1'b0, 30'h100, 4'hF, 0, 1, 1'b0, 0);

        // 4-beat write across the address wrap, zero-wait slave
        set_slave(0, 0, 0, 0, 0, -1);
        run_cmd("wr_wrap", 1'b1, 30'h3FFFFFFE, 4'hF, 3, 4, 1'b0, 4);

        // 8-beat read, random wait states and ack glitches outside stb
        set_slave(0, 3, 0, 1, 0, -1);
        run_cmd("rd_gaps", 1'b0, 30'h200, 4'hC, 7, 8, 1'b0, 0);

        // 4-beat write with source gaps and glitch acks while stb low
        set_slave(0, 1, 0, 1, 1, -1);
        run_cmd("wr_gaps", 1'b1, 30'h0ABC, 4'h5, 3, 4, 1'b0, 0);

        // bus error on beat 2 of 4, ack raised together with err
        set_slave(0, 0, 0, 0, 0, 2);
        run_cmd("rd_err", 1'b0, 30'h300, 4'hF, 3, 2, 1'b1, 3);

        // silent slave trips the 16-cycle timeout
        set_slave(0, 0, 1, 0, 0, -1);
        run_cmd("rd_tmo", 1'b0, 30'h040, 4'hF, 0, 0, 1'b1, 16);

        // asynchronous reset in the middle of a burst
        set_slave(0, 1, 0, 0, 0, -1);
        issue_cmd(1'b0, 30'h400, 4'hF, 7, 8);
        repeat (5) @(negedge sys_clk);
        #2;
        check("mid_burst_cyc", wb_cyc_o, 1'b1);
        dc = done_cnt;
        sys_rst_n = 1'b0;
        #1;
        check("rst_async", {wb_cyc_o, wb_stb_o, done, rd_valid, cmd_ready}, '0);
        repeat (3) @(negedge sys_clk);
        exp_beats.delete();
        rd_exp.delete();
        #2;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("ready_after_rst", cmd_ready, 1'b1);
        repeat (3) @(negedge sys_clk);
        #1;
        check("no_done_on_rst", done_cnt, dc);

        // single classic write after recovery
        set_slave(0, 0, 0, 0, 0, -1);
        run_cmd("wr_single", 1'b1, 30'h3FFFFFFF, 4'h3, 0, 1, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
